// File: rtl/cordic_input_launcher.sv
// cordic_input_launcher: clocked transmit side of the async CORDIC sqrt handshake.
// Launches one FP32 operand per 4-phase bundled-data cycle; ack is synchronized.
module cordic_input_launcher #(
    parameter int FP32           = 31,
    parameter int SETUP_CYCLES   = 2,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic          ck,
    input  logic          arst,
    input  logic          valid_i,
    output logic          ready_o,
    input  logic [FP32:0] data_i,
    output logic [FP32:0] data_o,
    output logic          req_o,
    input  logic          ack_i,
    output logic          busy_o,
    output logic          timeout_o,
    input  logic          clr_timeout_i
);

    localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TSAT = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TSET =
        TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [3:0] CNT_INIT = 4'(SETUP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        REQ_HI,
        REQ_LO
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [TW-1:0]        tcnt_q, tcnt_d;
    logic [TW-1:0]        tcnt_inc;
    logic                 req_q, req_d;
    logic [FP32:0]        data_q, data_d;
    logic                 tmo_q, tmo_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                 ack_s;
    logic                 waiting;
    logic                 tmo_set;

    assign ack_s     = sync_q[SYNC_STAGES-1];
    assign sync_d    = {sync_q[SYNC_STAGES-2:0], ack_i};
    assign ready_o   = (state_q == IDLE) && !ack_s;
    assign busy_o    = (state_q != IDLE);
    assign req_o     = req_q;
    assign data_o    = data_q;
    assign timeout_o = tmo_q;
    assign tcnt_inc  = (tcnt_q == TSAT) ? tcnt_q : tcnt_q + TW'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tcnt_d  = tcnt_q;
        req_d   = req_q;
        data_d  = data_q;
        waiting = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (valid_i && ready_o) begin
                    data_d  = data_i;
                    cnt_d   = CNT_INIT;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == 4'd0) begin
                    req_d   = 1'b1;
                    tcnt_d  = '0;
                    state_d = REQ_HI;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            REQ_HI: begin
                if (ack_s) begin
                    req_d   = 1'b0;
                    tcnt_d  = '0;
                    state_d = REQ_LO;
                end else begin
                    waiting = 1'b1;
                    tcnt_d  = tcnt_inc;
                end
            end
            REQ_LO: begin
                if (!ack_s) begin
                    state_d = IDLE;
                end else begin
                    waiting = 1'b1;
                    tcnt_d  = tcnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // tcnt saturates one past TSET, so the flag fires once per stalled phase.
    always_comb begin
        tmo_set = waiting && (TIMEOUT_CYCLES != 0) && (tcnt_q == TSET);
        tmo_d   = tmo_q;
        if (tmo_set) begin
            tmo_d = 1'b1;
        end else if (clr_timeout_i) begin
            tmo_d = 1'b0;
        end
    end

    always_ff @(posedge ck or negedge arst) begin
        if (!arst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tcnt_q  <= '0;
            req_q   <= 1'b0;
            data_q  <= '0;
            tmo_q   <= 1'b0;
            sync_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tcnt_q  <= tcnt_d;
            req_q   <= req_d;
            data_q  <= data_d;
            tmo_q   <= tmo_d;
            sync_q  <= sync_d;
        end
    end

endmodule
